// File: rtl/wb_regfile.sv
// Writeback stage: selects the MEM/WB result, commits it to the architectural
// register file, and serves two combinational read ports with write-through bypass.
module wb_regfile #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteW,
  input  logic             MemtoRegW,
  input  logic [WIDTH-1:0] ReadDataW,
  input  logic [WIDTH-1:0] ALUOutW,
  input  logic [4:0]       WriteRegW,
  input  logic [WIDTH-1:0] PCPlus4W,
  input  logic             JalW,
  input  logic [4:0]       RA1,
  input  logic [4:0]       RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic [WIDTH-1:0] ResultW,
  output logic [WIDTH-1:0] WbCount
);

  localparam logic [4:0] LINK_ADDR = 5'(LINK_REG);

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [WIDTH-1:0] wb_count_q;
  logic [WIDTH-1:0] wb_count_d;

  logic [WIDTH-1:0] result_w;
  logic [4:0]       dest_w;
  logic             we_w;

  always_comb begin
    if (JalW)           result_w = PCPlus4W;
    else if (MemtoRegW) result_w = ReadDataW;
    else                result_w = ALUOutW;
    dest_w = JalW ? LINK_ADDR : WriteRegW;
    we_w   = RegWriteW && (dest_w != 5'd0);
  end

  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (we_w) begin
      regs_d[dest_w] = result_w;
      wb_count_d     = wb_count_q + WIDTH'(1);
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

  // Bypass lets decode see a value being written back in the same cycle.
  always_comb begin
    if (RA1 == 5'd0)                     RD1 = '0;
    else if (we_w && (RA1 == dest_w))    RD1 = result_w;
    else                                 RD1 = regs_q[RA1];
    if (RA2 == 5'd0)                     RD2 = '0;
    else if (we_w && (RA2 == dest_w))    RD2 = result_w;
    else                                 RD2 = regs_q[RA2];
  end

  assign ResultW = result_w;
  assign WbCount = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized bench for wb_regfile: a driver pushes expected outputs into a
// queue, a monitor pops and compares them against the sampled DUT outputs.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW, MemtoRegW, JalW;
  logic [31:0] ReadDataW, ALUOutW, PCPlus4W;
  logic [4:0]  WriteRegW, RA1, RA2;
  logic [31:0] RD1, RD2, ResultW, WbCount;

  wb_regfile #(.WIDTH(32), .NREG(32), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WriteRegW(WriteRegW),
    .PCPlus4W(PCPlus4W), .JalW(JalW), .RA1(RA1), .RA2(RA2),
    .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .WbCount(WbCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd1, rd2, res, cnt;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0;
  endtask

  function automatic logic [31:0] m_result();
    if (JalW)      return PCPlus4W;
    if (MemtoRegW) return ReadDataW;
    return ALUOutW;
  endfunction

  function automatic logic [4:0] m_dest();
    return JalW ? 5'd31 : WriteRegW;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (RegWriteW && m_dest() != 5'd0 && a == m_dest()) return m_result();
    return m_regs[a];
  endfunction

  // Apply one cycle of inputs at the falling edge, queue the expected outputs
  // for that cycle, then update the model with what the next rising edge commits.
  task automatic drive(input logic rw, input logic m2r, input logic jal,
                       input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [4:0] wr,
                       input logic [4:0] a1, input logic [4:0] a2, input string nm);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    RegWriteW = rw; MemtoRegW = m2r; JalW = jal;
    ReadDataW = rdat; ALUOutW = alu; PCPlus4W = pc4;
    WriteRegW = wr; RA1 = a1; RA2 = a2;
    e.name = nm;
    e.rd1  = m_read(a1);
    e.rd2  = m_read(a2);
    e.res  = m_result();
    e.cnt  = m_cnt;
    sbq.push_back(e);
    if (rw && m_dest() != 5'd0) begin
      m_regs[m_dest()] = m_result();
      m_cnt = m_cnt + 32'd1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({e.name, "_rd1"}, RD1, e.rd1);
      check({e.name, "_rd2"}, RD2, e.rd2);
      check({e.name, "_res"}, ResultW, e.res);
      check({e.name, "_cnt"}, WbCount, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       rw, m2r, jal;
    logic [4:0] wr, a1, a2;
    rst = 1'b1;
    RegWriteW = 1'b0; MemtoRegW = 1'b0; JalW = 1'b0;
    ReadDataW = '0; ALUOutW = '0; PCPlus4W = '0;
    WriteRegW = '0; RA1 = 5'd5; RA2 = 5'd0;
    model_clear();
    #1;
    check("async_reset_rd1", RD1, 32'h0);
    check("async_reset_cnt", WbCount, 32'h0);
    repeat (2) @(posedge clk);

    drive(0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0, "reset");
    drive(1, 0, 0, 32'h0, 32'h0000_1234, 0, 5'd8, 5'd3, 5'd0, "wr8");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd0, "rd8");
    drive(1, 1, 0, 32'hDEAD_BEEF, 32'h5555_5555, 0, 5'd9, 5'd8, 5'd9, "byp9");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd9, "rd9");
    drive(1, 1, 1, 32'h1111_1111, 32'h2222_2222, 32'h0040_0010, 5'd4, 5'd4, 5'd31, "jal");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd31, "jalrd");
    drive(0, 0, 1, 0, 0, 32'h0000_0abc, 5'd7, 5'd31, 5'd7, "jalnowr");
    drive(1, 0, 0, 0, 32'hFFFF_FFFF, 0, 5'd0, 5'd0, 5'd8, "wr0");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd31, "wr0rd");

    // Backdoor the counter to its maximum so one more write wraps it.
    @(posedge clk);
    #1;
    dut.wb_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 32'hCAFE_0001, 0, 5'd8, 5'd8, 5'd9, "wrap_pre");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd8, 5'd9, "wrap");
    #3;
    rst = 1'b1;
    #1;
    check("midrst_rd1", RD1, 32'h0);
    check("midrst_rd2", RD2, 32'h0);
    check("midrst_cnt", WbCount, 32'h0);
    model_clear();

    // A write pending in a cycle where reset arrives must be discarded.
    drive(1, 0, 0, 0, 32'h7777_7777, 0, 5'd7, 5'd7, 5'd0, "pend");
    #3;
    rst = 1'b1;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0, "pend_drop");
    drive(1, 0, 0, 0, 32'h0000_00AA, 0, 5'd7, 5'd0, 5'd0, "post_rst_wr");
    drive(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7, "post_rst_rd");

    for (int n = 0; n < 300; n++) begin
      rw  = ($urandom % 4) != 0;
      m2r = $urandom % 2;
      jal = ($urandom % 8) == 0;
      wr  = 5'($urandom % 32);
      a1  = (($urandom % 3) == 0) ? wr : 5'($urandom % 32);
      a2  = (($urandom % 3) == 0) ? 5'd31 : 5'($urandom % 32);
      drive(rw, m2r, jal, $urandom, $urandom, $urandom, wr, a1, a2, "rand");
      if (($urandom % 50) == 0) begin
        #3;
        rst = 1'b1;
        model_clear();
      end
    end

    drive(0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, "final");
    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(negedge clk);
    #3;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
